usd_apu_bridge: RTL and testbench

- APU-clock-side sequencer directly upstream of the micro-SD controller top level.
- Turns one block read/write request (512-byte block, 64 x 64-bit words) into:
  - a 72-bit command word pushed into the command FIFO;
  - for writes, 64 write-data words pushed into the command-data FIFO;
  - for reads, 64 words drained from the result-data FIFO.
- Pops the 36-bit result word and reports completion with status and tag.
- One request in flight at a time.

---
 rtl/usd_pkg.sv | 38 +++
 rtl/usd_apu_bridge.sv | 196 +++++++++++++++++++
 tb/tb_usd_apu_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usd_pkg.sv
// Shared definitions for the micro-SD APU bridge: FSM states, status codes and
// the layout of the 72-bit command word.
package usd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_CMD,
    ST_WAIT_RES,
    ST_CAP_RES,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  localparam logic [3:0] STAT_OK      = 4'd0;
  localparam logic [3:0] STAT_TIMEOUT = 4'd15;

  localparam int CW_TAG_LSB   = 64;
  localparam int CW_IDX_LSB   = 58;
  localparam int CW_WRITE_BIT = 49;

  localparam int CMD_RD_IDX_DEFAULT = 17;
  localparam int CMD_WR_IDX_DEFAULT = 24;

  function automatic logic [71:0] usd_cmd_pack(input logic [7:0]  tag,
                                               input logic [5:0]  idx,
                                               input logic        write,
                                               input logic [31:0] addr);
    logic [71:0] word;
    word                   = '0;
    word[CW_TAG_LSB +: 8]  = tag;
    word[CW_IDX_LSB +: 6]  = idx;
    word[CW_WRITE_BIT]     = write;
    word[31:0]             = addr;
    return word;
  endfunction

endpackage

// File: rtl/usd_apu_bridge.sv
// APU-side sequencer in front of the micro-SD controller: turns one block
// request into command/data FIFO traffic and reports completion.
module usd_apu_bridge
  import usd_pkg::*;
#(
  parameter int BLOCK_WORDS    = 64,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CMD_RD_IDX     = CMD_RD_IDX_DEFAULT,
  parameter int CMD_WR_IDX     = CMD_WR_IDX_DEFAULT
) (
  input  logic        apuClk,
  input  logic        sysRstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [7:0]  reqTag,
  input  logic        wrDataValid,
  output logic        wrDataReady,
  input  logic [63:0] wrData,
  output logic        rdDataValid,
  output logic [63:0] rdData,
  output logic        doneValid,
  output logic [7:0]  doneTag,
  output logic [3:0]  doneStatus,
  output logic [31:0] doneResp,
  output logic [71:0] cmdFifoData,
  output logic        cmdFifoWrEn,
  input  logic        cmdFifoSpace,
  output logic [71:0] cmdDataFifoData,
  output logic        cmdDataFifoWrEn,
  input  logic        cmdDataAlmostFull,
  input  logic        resultFifoEmpty,
  output logic        resultFifoRdEn,
  input  logic [35:0] resultFifoData,
  input  logic        resultDataEmpty,
  output logic        resultDataFifoRdEn,
  input  logic [71:0] resultDataFifoData,
  output logic [7:0]  orphanCount
);

  localparam int CW = $clog2(BLOCK_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WORD  = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] BLOCK_CNT  = CW'(BLOCK_WORDS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    RD_IDX     = 6'(CMD_RD_IDX);
  localparam logic [5:0]    WR_IDX     = 6'(CMD_WR_IDX);

  state_t        state, next_state;
  logic          run;
  logic          is_write;
  logic [31:0]   addr_q;
  logic [7:0]    tag_q;
  logic [CW-1:0] word_cnt, pop_cnt, rcv_cnt;
  logic [TW-1:0] timer;
  logic [3:0]    status_q;
  logic [31:0]   resp_q;
  logic [7:0]    orphan_cnt;
  logic [71:0]   cmd_data_q;
  logic          cmd_data_we_q;
  logic          rd_valid_q;

  logic req_ready, wr_ready, cmd_we, res_pop, data_pop, done;
  logic req_fire, wr_fire;
  logic rd_unused;

  assign req_fire  = req_ready & reqValid;
  assign wr_fire   = wr_ready & wrDataValid;
  assign rd_unused = &{1'b0, resultDataFifoData[71:64]};

  // run stays low for the first cycle after reset so every strobe is held at
  // zero while reset is asserted, regardless of the FIFO flags.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    cmd_we     = 1'b0;
    res_pop    = 1'b0;
    data_pop   = 1'b0;
    done       = 1'b0;
    if (run) begin
      case (state)
        ST_IDLE: begin
          if (!resultFifoEmpty) begin
            res_pop = 1'b1;
          end else begin
            req_ready = 1'b1;
            if (reqValid) next_state = reqWrite ? ST_WR_DATA : ST_CMD;
          end
        end
        ST_WR_DATA: begin
          wr_ready = !cmdDataAlmostFull;
          if (wr_ready && wrDataValid && word_cnt == LAST_WORD) next_state = ST_CMD;
        end
        ST_CMD: begin
          // hold the command until the last data word has left the register
          if (cmdFifoSpace && !cmd_data_we_q) begin
            cmd_we     = 1'b1;
            next_state = ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (!resultFifoEmpty) begin
            res_pop    = 1'b1;
            next_state = ST_CAP_RES;
          end else if (timer == TIMER_LAST) begin
            next_state = ST_DONE;
          end
        end
        ST_CAP_RES: begin
          if (!is_write && resultFifoData[35:32] == STAT_OK) next_state = ST_RD_DATA;
          else next_state = ST_DONE;
        end
        ST_RD_DATA: begin
          data_pop = !resultDataEmpty && (pop_cnt < BLOCK_CNT);
          if (rd_valid_q && rcv_cnt == LAST_WORD) next_state = ST_DONE;
        end
        ST_DONE: begin
          done       = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // timer counts cycles elapsed since the command write, so expiry lands the
  // completion exactly TIMEOUT_CYCLES cycles after the command.
  always_ff @(posedge apuClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state         <= ST_IDLE;
      run           <= 1'b0;
      is_write      <= 1'b0;
      addr_q        <= '0;
      tag_q         <= '0;
      word_cnt      <= '0;
      pop_cnt       <= '0;
      rcv_cnt       <= '0;
      timer         <= '0;
      status_q      <= '0;
      resp_q        <= '0;
      orphan_cnt    <= '0;
      cmd_data_q    <= '0;
      cmd_data_we_q <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      run           <= 1'b1;
      state         <= next_state;
      cmd_data_we_q <= wr_fire;
      rd_valid_q    <= data_pop;
      if (req_fire) begin
        is_write <= reqWrite;
        addr_q   <= reqAddr;
        tag_q    <= reqTag;
        word_cnt <= '0;
      end
      if (state == ST_IDLE && res_pop && orphan_cnt != 8'hFF) orphan_cnt <= orphan_cnt + 8'd1;
      if (wr_fire) begin
        cmd_data_q <= {8'h00, wrData};
        word_cnt   <= word_cnt + CW'(1);
      end
      if (cmd_we) timer <= TW'(1);
      else if (state == ST_WAIT_RES) timer <= timer + TW'(1);
      if (state == ST_WAIT_RES && next_state == ST_DONE) begin
        status_q <= STAT_TIMEOUT;
        resp_q   <= '0;
      end
      if (state == ST_CAP_RES) begin
        status_q <= resultFifoData[35:32];
        resp_q   <= resultFifoData[31:0];
        pop_cnt  <= '0;
        rcv_cnt  <= '0;
      end
      if (data_pop) pop_cnt <= pop_cnt + CW'(1);
      if (rd_valid_q) rcv_cnt <= rcv_cnt + CW'(1);
    end
  end

  assign reqReady           = req_ready;
  assign wrDataReady        = wr_ready;
  assign cmdFifoWrEn        = cmd_we;
  assign cmdFifoData        = cmd_we ? usd_cmd_pack(tag_q, is_write ? WR_IDX : RD_IDX, is_write, addr_q) : '0;
  assign cmdDataFifoWrEn    = cmd_data_we_q;
  assign cmdDataFifoData    = cmd_data_q;
  assign resultFifoRdEn     = res_pop;
  assign resultDataFifoRdEn = data_pop;
  assign rdDataValid        = rd_valid_q;
  assign rdData             = rd_valid_q ? resultDataFifoData[63:0] : '0;
  assign doneValid          = done;
  assign doneTag            = done ? tag_q : '0;
  assign doneStatus         = done ? status_q : '0;
  assign doneResp           = done ? resp_q : '0;
  assign orphanCount        = orphan_cnt;

endmodule

// File: tb/tb_usd_apu_bridge.sv
// Scoreboard bench for usd_apu_bridge: models the surrounding FIFOs and checks
// every FIFO write, read strobe and completion against queued expectations.
module tb_usd_apu_bridge;

  localparam int BLOCK_WORDS = 64;
  localparam int TIMEOUT     = 100;

  logic        apuClk, sysRstN;
  logic        reqValid, reqReady, reqWrite;
  logic [31:0] reqAddr;
  logic [7:0]  reqTag;
  logic        wrDataValid, wrDataReady;
  logic [63:0] wrData;
  logic        rdDataValid;
  logic [63:0] rdData;
  logic        doneValid;
  logic [7:0]  doneTag;
  logic [3:0]  doneStatus;
  logic [31:0] doneResp;
  logic [71:0] cmdFifoData;
  logic        cmdFifoWrEn, cmdFifoSpace;
  logic [71:0] cmdDataFifoData;
  logic        cmdDataFifoWrEn, cmdDataAlmostFull;
  logic        resultFifoEmpty, resultFifoRdEn;
  logic [35:0] resultFifoData;
  logic        resultDataEmpty, resultDataFifoRdEn;
  logic [71:0] resultDataFifoData;
  logic [7:0]  orphanCount;

  usd_apu_bridge #(.BLOCK_WORDS(BLOCK_WORDS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .apuClk(apuClk), .sysRstN(sysRstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqTag(reqTag),
    .wrDataValid(wrDataValid), .wrDataReady(wrDataReady), .wrData(wrData),
    .rdDataValid(rdDataValid), .rdData(rdData),
    .doneValid(doneValid), .doneTag(doneTag), .doneStatus(doneStatus), .doneResp(doneResp),
    .cmdFifoData(cmdFifoData), .cmdFifoWrEn(cmdFifoWrEn), .cmdFifoSpace(cmdFifoSpace),
    .cmdDataFifoData(cmdDataFifoData), .cmdDataFifoWrEn(cmdDataFifoWrEn),
    .cmdDataAlmostFull(cmdDataAlmostFull),
    .resultFifoEmpty(resultFifoEmpty), .resultFifoRdEn(resultFifoRdEn),
    .resultFifoData(resultFifoData),
    .resultDataEmpty(resultDataEmpty), .resultDataFifoRdEn(resultDataFifoRdEn),
    .resultDataFifoData(resultDataFifoData),
    .orphanCount(orphanCount)
  );

  initial apuClk = 1'b0;
  always #5 apuClk = ~apuClk;

  int err_count   = 0;
  int check_count = 0;
  int cyc = 0;
  int cmd_cycle = 0, done_cycle = 0, last_rd_cycle = 0;
  int data_writes = 0, cmd_writes = 0, rd_strobes = 0, done_count = 0, data_pops = 0;

  logic [63:0] exp_data[$];
  logic [71:0] exp_cmd[$];
  logic [63:0] exp_rd[$];
  logic [43:0] exp_done[$];
  logic [35:0] res_q[$];
  logic [63:0] rdq[$];
  bit toggle_mode = 1'b0;
  bit phase = 1'b0;
  bit s_res_pop, s_data_pop;

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] expCmd(input logic [7:0] tag, input logic [5:0] idx,
                                         input logic wr, input logic [31:0] addr);
    return {tag, idx, 8'h00, wr, 17'h0, addr};
  endfunction

  task automatic tick();
    @(posedge apuClk);
    #2;
  endtask

  // FIFO models and scoreboard: look at DUT strobes mid-cycle, apply the
  // resulting FIFO updates just after the edge that performs them.
  always begin
    @(negedge apuClk);
    s_res_pop  = resultFifoRdEn;
    s_data_pop = resultDataFifoRdEn;
    if (cmdDataFifoWrEn) begin
      data_writes++;
      if (exp_data.size() == 0) checkOutput("data_unexpected", cmdDataFifoWrEn, 0);
      else checkOutput("cmd_data", cmdDataFifoData, {8'h00, exp_data.pop_front()});
    end
    if (cmdFifoWrEn) begin
      cmd_writes++;
      cmd_cycle = cyc;
      checkOutput("cmd_space", cmdFifoSpace, 1);
      checkOutput("data_before_cmd", exp_data.size(), 0);
      if (exp_cmd.size() == 0) checkOutput("cmd_unexpected", cmdFifoWrEn, 0);
      else checkOutput("cmd_word", cmdFifoData, exp_cmd.pop_front());
    end
    if (resultFifoRdEn) checkOutput("res_pop_nonempty", resultFifoEmpty, 0);
    if (resultDataFifoRdEn) begin
      data_pops++;
      checkOutput("data_pop_nonempty", resultDataEmpty, 0);
    end
    if (cmdDataAlmostFull) checkOutput("wr_blocked", wrDataReady, 0);
    if (rdDataValid) begin
      rd_strobes++;
      last_rd_cycle = cyc;
      if (exp_rd.size() == 0) checkOutput("rd_unexpected", rdDataValid, 0);
      else checkOutput("rd_data", rdData, exp_rd.pop_front());
    end
    if (doneValid) begin
      done_count++;
      done_cycle = cyc;
      checkOutput("rd_all_before_done", exp_rd.size(), 0);
      if (exp_done.size() == 0) checkOutput("done_unexpected", doneValid, 0);
      else checkOutput("done_fields", {doneTag, doneStatus, doneResp}, exp_done.pop_front());
    end
    @(posedge apuClk);
    cyc++;
    #1;
    if (s_res_pop && res_q.size() != 0) resultFifoData = res_q.pop_front();
    if (s_data_pop && rdq.size() != 0) resultDataFifoData = {8'h00, rdq.pop_front()};
    phase           = ~phase;
    resultFifoEmpty = (res_q.size() == 0);
    resultDataEmpty = (rdq.size() == 0) || (toggle_mode && phase);
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, |{reqReady, wrDataReady, rdDataValid, rdData, doneValid, doneTag,
                       doneStatus, doneResp, cmdFifoData, cmdFifoWrEn, cmdDataFifoData,
                       cmdDataFifoWrEn, resultFifoRdEn, resultDataFifoRdEn, orphanCount}, 0);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] tag);
    bit accepted = 1'b0;
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqTag   = tag;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge apuClk);
      accepted = reqReady;
    end
    tick();
    reqValid = 1'b0;
    if (!accepted) checkOutput("req_accept_timeout", reqReady, 1);
  endtask

  task automatic applyWriteData(input bit bp, input logic [63:0] base);
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      bit accepted = 1'b0;
      wrData      = base + 64'(i);
      wrDataValid = 1'b1;
      if (bp && i == 10) begin
        cmdDataAlmostFull = 1'b1;
        repeat (10) tick();
        cmdDataAlmostFull = 1'b0;
      end
      for (int n = 0; n < 200 && !accepted; n++) begin
        @(negedge apuClk);
        accepted = wrDataReady;
      end
      tick();
      if (!accepted) begin
        checkOutput("wr_accept_timeout", wrDataReady, 1);
        break;
      end
    end
    wrDataValid = 1'b0;
  endtask

  task automatic waitCmd(input int c0);
    for (int n = 0; n < 300 && cmd_writes == c0; n++) tick();
    if (cmd_writes == c0) checkOutput("cmd_wait_timeout", cmdFifoWrEn, 1);
  endtask

  task automatic waitDone(input int n0);
    for (int n = 0; n < 1000 && done_count == n0; n++) tick();
    if (done_count == n0) checkOutput("done_wait_timeout", doneValid, 1);
  endtask

  int d0, c0, n0, r0, p0, sp_cycle;

  initial begin
    sysRstN = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqTag = '0;
    wrDataValid = 1'b0; wrData = '0;
    cmdFifoSpace = 1'b1; cmdDataAlmostFull = 1'b0;
    resultFifoEmpty = 1'b1; resultFifoData = '0;
    resultDataEmpty = 1'b1; resultDataFifoData = '0;
    repeat (3) tick();
    checkResetOutputs("reset_outputs");
    sysRstN = 1'b1;
    repeat (2) tick();

    // plain block write
    $display("[TB] block write");
    for (int i = 0; i < BLOCK_WORDS; i++) exp_data.push_back(64'(i));
    exp_cmd.push_back(72'h5A_60_02_00_00_00_00_12_34);
    exp_done.push_back({8'h5A, 4'h0, 32'h0000_0900});
    d0 = data_writes; c0 = cmd_writes; n0 = done_count;
    applyStimulus(1'b1, 32'h0000_1234, 8'h5A);
    applyWriteData(1'b0, 64'h0);
    waitCmd(c0);
    res_q.push_back({4'h0, 32'h0000_0900});
    waitDone(n0);
    checkOutput("wr_data_total", data_writes - d0, BLOCK_WORDS);
    checkOutput("wr_cmd_total", cmd_writes - c0, 1);

    // block read, result-data FIFO empty every other cycle
    $display("[TB] block read");
    toggle_mode = 1'b1;
    exp_cmd.push_back(expCmd(8'h01, 6'd17, 1'b0, 32'h10));
    exp_done.push_back({8'h01, 4'h0, 32'h0000_0ABC});
    c0 = cmd_writes; n0 = done_count; r0 = rd_strobes;
    applyStimulus(1'b0, 32'h10, 8'h01);
    waitCmd(c0);
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      rdq.push_back(64'hA0 + 64'(i));
      exp_rd.push_back(64'hA0 + 64'(i));
    end
    res_q.push_back({4'h0, 32'h0000_0ABC});
    waitDone(n0);
    checkOutput("rd_strobe_total", rd_strobes - r0, BLOCK_WORDS);
    checkOutput("done_after_last_strobe", done_cycle > last_rd_cycle, 1);
    toggle_mode = 1'b0;

    // read with error status: no data drained
    $display("[TB] read with controller error");
    exp_cmd.push_back(expCmd(8'h33, 6'd17, 1'b0, 32'h20));
    exp_done.push_back({8'h33, 4'h3, 32'h0000_0005});
    c0 = cmd_writes; n0 = done_count; p0 = data_pops;
    applyStimulus(1'b0, 32'h20, 8'h33);
    waitCmd(c0);
    res_q.push_back({4'h3, 32'h0000_0005});
    waitDone(n0);
    checkOutput("err_no_data_pops", data_pops - p0, 0);

    // timeout, then a late result becomes an orphan
    $display("[TB] timeout and orphan");
    exp_cmd.push_back(expCmd(8'h44, 6'd17, 1'b0, 32'h30));
    exp_done.push_back({8'h44, 4'hF, 32'h0});
    c0 = cmd_writes; n0 = done_count;
    applyStimulus(1'b0, 32'h30, 8'h44);
    waitCmd(c0);
    waitDone(n0);
    checkOutput("timeout_latency", done_cycle - cmd_cycle, TIMEOUT);
    n0 = done_count;
    res_q.push_back({4'h0, 32'hDEAD_BEEF});
    repeat (6) tick();
    checkOutput("orphan_count", orphanCount, 1);
    checkOutput("orphan_drained", res_q.size(), 0);
    checkOutput("orphan_no_done", done_count - n0, 0);

    // write with data and command back-pressure
    $display("[TB] write with back-pressure");
    for (int i = 0; i < BLOCK_WORDS; i++) exp_data.push_back(64'h1000 + 64'(i));
    exp_cmd.push_back(expCmd(8'h77, 6'd24, 1'b1, 32'h0000_ABCD));
    exp_done.push_back({8'h77, 4'h0, 32'h0000_0111});
    d0 = data_writes; c0 = cmd_writes; n0 = done_count;
    applyStimulus(1'b1, 32'h0000_ABCD, 8'h77);
    applyWriteData(1'b1, 64'h1000);
    cmdFifoSpace = 1'b0;
    sp_cycle = cyc;
    repeat (5) tick();
    cmdFifoSpace = 1'b1;
    waitCmd(c0);
    checkOutput("cmd_after_space", cmd_cycle - sp_cycle >= 5, 1);
    res_q.push_back({4'h0, 32'h0000_0111});
    waitDone(n0);
    checkOutput("bp_data_total", data_writes - d0, BLOCK_WORDS);
    checkOutput("bp_cmd_total", cmd_writes - c0, 1);

    // reset in the middle of a read drain
    $display("[TB] reset mid read");
    toggle_mode = 1'b1;
    exp_cmd.push_back(expCmd(8'h66, 6'd17, 1'b0, 32'h40));
    c0 = cmd_writes; n0 = done_count; r0 = rd_strobes;
    applyStimulus(1'b0, 32'h40, 8'h66);
    waitCmd(c0);
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      rdq.push_back(64'h100 + 64'(i));
      exp_rd.push_back(64'h100 + 64'(i));
    end
    res_q.push_back({4'h0, 32'h0});
    for (int n = 0; n < 500 && rd_strobes - r0 < 20; n++) tick();
    checkOutput("pre_reset_strobes", rd_strobes - r0 >= 20, 1);
    @(negedge apuClk);
    #2;
    sysRstN = 1'b0;
    #1;
    checkResetOutputs("midop_reset_outputs");
    repeat (2) @(posedge apuClk);
    #2;
    res_q.delete(); rdq.delete(); exp_rd.delete(); exp_done.delete();
    exp_cmd.delete(); exp_data.delete();
    toggle_mode = 1'b0;
    resultFifoData = '0; resultDataFifoData = '0;
    resultFifoEmpty = 1'b1; resultDataEmpty = 1'b1;
    tick();
    sysRstN = 1'b1;
    repeat (2) tick();
    checkOutput("reset_no_done", done_count - n0, 0);

    // normal read after reset
    $display("[TB] read after reset");
    exp_cmd.push_back(expCmd(8'h02, 6'd17, 1'b0, 32'h50));
    exp_done.push_back({8'h02, 4'h0, 32'h0000_0077});
    c0 = cmd_writes; n0 = done_count; r0 = rd_strobes;
    applyStimulus(1'b0, 32'h50, 8'h02);
    waitCmd(c0);
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      rdq.push_back(64'h200 + 64'(i));
      exp_rd.push_back(64'h200 + 64'(i));
    end
    res_q.push_back({4'h0, 32'h0000_0077});
    waitDone(n0);
    checkOutput("post_reset_strobes", rd_strobes - r0, BLOCK_WORDS);
    checkOutput("post_reset_orphans", orphanCount, 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
